// File: rtl/cpu_pkg.sv
// Shared control-path types: FSM states, mux selects, trap causes and the
// decoded instruction-class register layout.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_IMEM_WAIT,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_WRITEBACK,
    ST_TRAP
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC_PLUS_4,
    WB_IMM
  } wb_sel_t;

  typedef enum logic [1:0] {
    PC_PLUS_4,
    PC_BRANCH_TARGET,
    PC_JAL_TARGET,
    PC_JALR_TARGET
  } pc_sel_t;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL,
    CAUSE_ENVIRONMENT,
    CAUSE_IMEM_TIMEOUT,
    CAUSE_DMEM_TIMEOUT
  } trap_cause_t;

  typedef struct packed {
    logic register_arith;
    logic immediate_arith;
    logic load;
    logic store;
    logic branch;
    logic immediate_jump;
    logic register_jump;
    logic load_upper;
    logic load_upper_pc;
    logic environment;
  } class_t;

  // True when exactly one instruction-class flag is set.
  function automatic logic exactly_one(input class_t c);
    logic [9:0]  v;
    int unsigned n;
    v = c;
    n = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      n = n + 32'(v[i]);
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Cycle counter for handshake waits; expires on the LIMIT-th enabled cycle.
module wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count;

  // Count enabled cycles, restart whenever the owning FSM changes state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// handshake timeouts, sticky traps and a retired-instruction counter.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT  = 255,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  input  logic                   imem_resp_valid,
  output logic                   ir_load,
  input  logic                   register_arith,
  input  logic                   immediate_arith,
  input  logic                   load,
  input  logic                   store,
  input  logic                   branch,
  input  logic                   immediate_jump,
  input  logic                   register_jump,
  input  logic                   load_upper,
  input  logic                   load_upper_pc,
  input  logic                   environment,
  input  logic                   opcode_valid,
  input  logic                   branch_taken,
  output logic                   dmem_req_valid,
  output logic                   dmem_req_write,
  input  logic                   dmem_req_ready,
  input  logic                   dmem_resp_valid,
  output logic                   alu_src_imm,
  output logic                   alu_a_pc,
  output logic                   reg_write_enable,
  output logic [1:0]             wb_sel,
  output logic                   pc_write,
  output logic [1:0]             pc_sel,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output logic [COUNT_WIDTH-1:0] instret
);

  state_t                 state, next_state;
  class_t                 cls, class_in;
  trap_cause_t            cause_q, next_cause;
  logic                   trap_q;
  logic [COUNT_WIDTH-1:0] instret_q;

  logic        in_wait, expired;
  logic        imem_req_c, ir_load_c, dmem_req_c, dmem_write_c;
  logic        src_imm_c, a_pc_c, rwe_c, pc_write_c;
  wb_sel_t     wb_sel_c;
  pc_sel_t     pc_sel_c;

  assign class_in = {register_arith, immediate_arith, load, store, branch,
                     immediate_jump, register_jump, load_upper, load_upper_pc,
                     environment};

  assign in_wait = (state == ST_FETCH) || (state == ST_IMEM_WAIT) ||
                   (state == ST_MEM_REQ) || (state == ST_MEM_WAIT);

  wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (next_state != state),
    .enable  (in_wait),
    .expired (expired)
  );

  // Next-state and output decode. Outputs are decoded from the registered
  // state (plus the handshake input where the same-cycle response matters,
  // e.g. ir_load), so they stay glitch-free with respect to FSM state.
  always_comb begin
    next_state   = state;
    next_cause   = cause_q;
    imem_req_c   = 1'b0;
    ir_load_c    = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_write_c = 1'b0;
    src_imm_c    = 1'b0;
    a_pc_c       = 1'b0;
    rwe_c        = 1'b0;
    pc_write_c   = 1'b0;
    wb_sel_c     = WB_ALU;
    pc_sel_c     = PC_PLUS_4;
    unique case (state)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_req_ready) begin
          next_state = ST_IMEM_WAIT;
        end else if (expired) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_IMEM_TIMEOUT;
        end
      end
      ST_IMEM_WAIT: begin
        if (imem_resp_valid) begin
          ir_load_c  = 1'b1;
          next_state = ST_DECODE;
        end else if (expired) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_IMEM_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (!opcode_valid || !exactly_one(class_in)) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_ILLEGAL;
        end else if (class_in.environment) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_ENVIRONMENT;
        end else begin
          next_state = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        src_imm_c = cls.immediate_arith | cls.load | cls.store | cls.register_jump;
        a_pc_c    = cls.load_upper_pc;
        if (cls.load || cls.store) begin
          next_state = ST_MEM_REQ;
        end else if (cls.branch) begin
          pc_write_c = 1'b1;
          pc_sel_c   = branch_taken ? PC_BRANCH_TARGET : PC_PLUS_4;
          next_state = ST_FETCH;
        end else begin
          rwe_c      = 1'b1;
          pc_write_c = 1'b1;
          next_state = ST_FETCH;
          if (cls.load_upper) begin
            wb_sel_c = WB_IMM;
          end else if (cls.immediate_jump || cls.register_jump) begin
            wb_sel_c = WB_PC_PLUS_4;
          end
          if (cls.immediate_jump) begin
            pc_sel_c = PC_JAL_TARGET;
          end else if (cls.register_jump) begin
            pc_sel_c = PC_JALR_TARGET;
          end
        end
      end
      ST_MEM_REQ: begin
        dmem_req_c   = 1'b1;
        dmem_write_c = cls.store;
        if (dmem_req_ready) begin
          next_state = ST_MEM_WAIT;
        end else if (expired) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_DMEM_TIMEOUT;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_resp_valid) begin
          if (cls.load) begin
            next_state = ST_WRITEBACK;
          end else begin
            pc_write_c = 1'b1;
            next_state = ST_FETCH;
          end
        end else if (expired) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_DMEM_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        rwe_c      = 1'b1;
        wb_sel_c   = WB_MEM;
        pc_write_c = 1'b1;
        next_state = ST_FETCH;
      end
      ST_TRAP: begin
        next_state = ST_TRAP;
      end
    endcase
  end

  // State, class register, trap status and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      cls       <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_ILLEGAL;
      instret_q <= '0;
    end else begin
      state <= next_state;
      if (state == ST_DECODE) begin
        cls <= class_in;
      end
      trap_q <= (next_state == ST_TRAP);
      if (state != ST_TRAP && next_state == ST_TRAP) begin
        cause_q <= next_cause;
      end
      instret_q <= instret_q + COUNT_WIDTH'(pc_write_c);
    end
  end

  // Strobes are gated by rst so they read 0 while reset is held.
  assign imem_req_valid   = imem_req_c & ~rst;
  assign ir_load          = ir_load_c & ~rst;
  assign dmem_req_valid   = dmem_req_c & ~rst;
  assign dmem_req_write   = dmem_write_c & ~rst;
  assign reg_write_enable = rwe_c & ~rst;
  assign pc_write         = pc_write_c & ~rst;
  assign alu_src_imm      = src_imm_c;
  assign alu_a_pc         = a_pc_c;
  assign wb_sel           = wb_sel_c;
  assign pc_sel           = pc_sel_c;
  assign trap             = trap_q;
  assign trap_cause       = cause_q;
  assign instret          = instret_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit (WAIT_LIMIT=4, COUNT_WIDTH=4).
module tb_control_unit;

  // Independent encodings of the select/cause outputs.
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3;
  localparam logic [1:0] PS_PC4 = 2'd0, PS_BR = 2'd1, PS_JAL = 2'd2, PS_JALR = 2'd3;
  localparam logic [1:0] C_ILL = 2'd0, C_ENV = 2'd1, C_IMEM = 2'd2, C_DMEM = 2'd3;

  // Flag bit positions in the bench's flags vector.
  localparam int F_RARITH = 0, F_IARITH = 1, F_LOAD = 2, F_STORE = 3, F_BRANCH = 4;
  localparam int F_JAL = 5, F_JALR = 6, F_LUI = 7, F_AUIPC = 8, F_ENV = 9;

  typedef struct packed {
    logic       imem_req_valid;
    logic       ir_load;
    logic       dmem_req_valid;
    logic       dmem_req_write;
    logic       alu_src_imm;
    logic       alu_a_pc;
    logic       reg_write_enable;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       trap;
    logic [1:0] trap_cause;
  } ctl_t;

  logic       clk, rst;
  logic       imem_req_valid, imem_req_ready, imem_resp_valid, ir_load;
  logic [9:0] flags;
  logic       opcode_valid, branch_taken;
  logic       dmem_req_valid, dmem_req_write, dmem_req_ready, dmem_resp_valid;
  logic       alu_src_imm, alu_a_pc, reg_write_enable, pc_write, trap;
  logic [1:0] wb_sel, pc_sel, trap_cause;
  logic [3:0] instret;

  ctl_t       ctl_obs;
  ctl_t       exp_q[$];
  logic [3:0] exp_instret;
  int         checks, errors;

  control_unit #(.WAIT_LIMIT(4), .COUNT_WIDTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_resp_valid  (imem_resp_valid),
    .ir_load          (ir_load),
    .register_arith   (flags[F_RARITH]),
    .immediate_arith  (flags[F_IARITH]),
    .load             (flags[F_LOAD]),
    .store            (flags[F_STORE]),
    .branch           (flags[F_BRANCH]),
    .immediate_jump   (flags[F_JAL]),
    .register_jump    (flags[F_JALR]),
    .load_upper       (flags[F_LUI]),
    .load_upper_pc    (flags[F_AUIPC]),
    .environment      (flags[F_ENV]),
    .opcode_valid     (opcode_valid),
    .branch_taken     (branch_taken),
    .dmem_req_valid   (dmem_req_valid),
    .dmem_req_write   (dmem_req_write),
    .dmem_req_ready   (dmem_req_ready),
    .dmem_resp_valid  (dmem_resp_valid),
    .alu_src_imm      (alu_src_imm),
    .alu_a_pc         (alu_a_pc),
    .reg_write_enable (reg_write_enable),
    .wb_sel           (wb_sel),
    .pc_write         (pc_write),
    .pc_sel           (pc_sel),
    .trap             (trap),
    .trap_cause       (trap_cause),
    .instret          (instret)
  );

  assign ctl_obs = {imem_req_valid, ir_load, dmem_req_valid, dmem_req_write,
                    alu_src_imm, alu_a_pc, reg_write_enable, wb_sel, pc_write,
                    pc_sel, trap, trap_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected-output builders.
  function automatic ctl_t c_fetch();
    ctl_t c;
    c = '0;
    c.imem_req_valid = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_irload();
    ctl_t c;
    c = '0;
    c.ir_load = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_exec(input logic rwe, input logic src, input logic apc,
                                  input logic [1:0] wb, input logic pcw, input logic [1:0] ps);
    ctl_t c;
    c = '0;
    c.reg_write_enable = rwe;
    c.alu_src_imm      = src;
    c.alu_a_pc         = apc;
    c.wb_sel           = wb;
    c.pc_write         = pcw;
    c.pc_sel           = ps;
    return c;
  endfunction

  function automatic ctl_t c_mreq(input logic wr);
    ctl_t c;
    c = '0;
    c.dmem_req_valid = 1'b1;
    c.dmem_req_write = wr;
    return c;
  endfunction

  function automatic ctl_t c_trap(input logic [1:0] cause);
    ctl_t c;
    c = '0;
    c.trap       = 1'b1;
    c.trap_cause = cause;
    return c;
  endfunction

  task automatic clear_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    flags           = '0;
    opcode_valid    = 1'b0;
    branch_taken    = 1'b0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
  endtask

  // One clock: expectation queued with the stimulus, compared at the falling
  // edge, then the rising edge commits; inputs return to idle afterwards.
  task automatic step(input string tag, input ctl_t e);
    ctl_t x;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    check({tag, "/ctl"}, 32'(ctl_obs), 32'(x));
    check({tag, "/instret"}, 32'(instret), 32'(exp_instret));
    if (x.pc_write && !rst) exp_instret = exp_instret + 4'd1;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_instret = '0;
    step("reset", '0);
    step("reset_hold", '0);
    rst = 1'b0;
  endtask

  task automatic fetch_decode(input logic [9:0] fl, input logic ov);
    imem_req_ready = 1'b1;
    step("fetch", c_fetch());
    imem_resp_valid = 1'b1;
    step("imem_wait", c_irload());
    flags = fl;
    opcode_valid = ov;
    step("decode", '0);
  endtask

  // Single-cycle classes: flag, alu_src_imm, alu_a_pc, wb_sel, pc_sel.
  logic [9:0] tab_fl  [6] = '{10'b1 << F_RARITH, 10'b1 << F_IARITH, 10'b1 << F_LUI,
                              10'b1 << F_AUIPC, 10'b1 << F_JAL, 10'b1 << F_JALR};
  logic       tab_src [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       tab_apc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [1:0] tab_wb  [6] = '{WB_ALU, WB_ALU, WB_IMM, WB_ALU, WB_PC4, WB_PC4};
  logic [1:0] tab_ps  [6] = '{PS_PC4, PS_PC4, PS_PC4, PS_PC4, PS_JAL, PS_JALR};

  initial begin
    checks = 0;
    errors = 0;
    exp_instret = '0;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // add, addi, lui, auipc, jal, jalr with single-cycle memories
    for (int i = 0; i < 6; i++) begin
      fetch_decode(tab_fl[i], 1'b1);
      step("exec_single", c_exec(1'b1, tab_src[i], tab_apc[i], tab_wb[i], 1'b1, tab_ps[i]));
      if (i == 0) check("add_instret", 32'(instret), 32'd1);
    end

    // beq taken then not taken
    fetch_decode(10'b1 << F_BRANCH, 1'b1);
    branch_taken = 1'b1;
    step("beq_taken", c_exec(1'b0, 1'b0, 1'b0, WB_ALU, 1'b1, PS_BR));
    fetch_decode(10'b1 << F_BRANCH, 1'b1);
    step("beq_not_taken", c_exec(1'b0, 1'b0, 1'b0, WB_ALU, 1'b1, PS_PC4));

    // lw: ready on 4th request cycle (limit cycle), stray response ignored
    fetch_decode(10'b1 << F_LOAD, 1'b1);
    step("lw_exec", c_exec(1'b0, 1'b1, 1'b0, WB_ALU, 1'b0, PS_PC4));
    for (int i = 0; i < 4; i++) begin
      dmem_req_ready  = (i == 3);
      dmem_resp_valid = (i == 1);
      step("lw_mem_req", c_mreq(1'b0));
    end
    step("lw_mem_wait", '0);
    dmem_resp_valid = 1'b1;
    step("lw_mem_resp", '0);
    step("lw_writeback", c_exec(1'b1, 1'b0, 1'b0, WB_MEM, 1'b1, PS_PC4));

    // sw: immediate handshake, pc advances on response
    fetch_decode(10'b1 << F_STORE, 1'b1);
    step("sw_exec", c_exec(1'b0, 1'b1, 1'b0, WB_ALU, 1'b0, PS_PC4));
    dmem_req_ready = 1'b1;
    step("sw_mem_req", c_mreq(1'b1));
    dmem_resp_valid = 1'b1;
    step("sw_mem_resp", c_exec(1'b0, 1'b0, 1'b0, WB_ALU, 1'b1, PS_PC4));

    // fetch ready on 4th cycle, response on 4th wait cycle: no timeout
    for (int i = 0; i < 4; i++) begin
      imem_req_ready  = (i == 3);
      imem_resp_valid = (i == 1);
      step("slow_fetch", c_fetch());
    end
    for (int i = 0; i < 3; i++) step("slow_imem_wait", '0);
    imem_resp_valid = 1'b1;
    step("slow_imem_resp", c_irload());
    flags = 10'b1 << F_RARITH;
    opcode_valid = 1'b1;
    step("slow_decode", '0);
    step("slow_exec", c_exec(1'b1, 1'b0, 1'b0, WB_ALU, 1'b1, PS_PC4));

    // five more retirements: 16th wraps the 4-bit counter
    for (int i = 0; i < 5; i++) begin
      fetch_decode(10'b1 << F_RARITH, 1'b1);
      step("wrap_exec", c_exec(1'b1, 1'b0, 1'b0, WB_ALU, 1'b1, PS_PC4));
    end
    check("instret_wrap", 32'(instret), 32'd0);

    // ecall -> environment trap
    fetch_decode(10'b1 << F_ENV, 1'b1);
    step("ecall_trap", c_trap(C_ENV));
    step("ecall_trap_hold", c_trap(C_ENV));
    do_reset();

    // opcode_valid=0 -> illegal trap, later responses ignored
    fetch_decode(10'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      imem_resp_valid = 1'b1;
      imem_req_ready  = 1'b1;
      step("illegal_trap", c_trap(C_ILL));
    end
    do_reset();
    step("post_reset_fetch", c_fetch());
    do_reset();

    // two class flags -> illegal
    fetch_decode((10'b1 << F_RARITH) | (10'b1 << F_IARITH), 1'b1);
    step("multi_flag_trap", c_trap(C_ILL));
    do_reset();

    // fetch never ready -> imem timeout after 4 fetch cycles
    for (int i = 0; i < 4; i++) step("imem_stall", c_fetch());
    step("imem_timeout", c_trap(C_IMEM));
    step("imem_timeout_hold", c_trap(C_IMEM));
    do_reset();

    // data request never ready -> dmem timeout
    fetch_decode(10'b1 << F_LOAD, 1'b1);
    step("dto_exec", c_exec(1'b0, 1'b1, 1'b0, WB_ALU, 1'b0, PS_PC4));
    for (int i = 0; i < 4; i++) step("dmem_stall", c_mreq(1'b0));
    step("dmem_timeout", c_trap(C_DMEM));
    do_reset();

    // reset mid-transaction abandons the store and restarts at fetch
    fetch_decode(10'b1 << F_STORE, 1'b1);
    step("abort_exec", c_exec(1'b0, 1'b1, 1'b0, WB_ALU, 1'b0, PS_PC4));
    step("abort_mem_req", c_mreq(1'b1));
    do_reset();
    step("abort_refetch", c_fetch());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
